// File: rtl/wb_dual_port_mem_model_if.sv
// Wishbone instruction + data bus bundle for wb_dual_port_mem_model.
// Ports: iwb_* fetch channel, dwb_* load/store channel; master/slave modports.
interface wb_dual_port_mem_model_if;
    logic [31:0] iwb_adr_i;
    logic        iwb_cyc_i;
    logic        iwb_stb_i;
    logic [31:0] iwb_dat_o;
    logic        iwb_ack_o;
    logic        iwb_err_o;

    logic [31:0] dwb_adr_i;
    logic [31:0] dwb_dat_i;
    logic        dwb_we_i;
    logic [3:0]  dwb_sel_i;
    logic        dwb_cyc_i;
    logic        dwb_stb_i;
    logic [31:0] dwb_dat_o;
    logic        dwb_ack_o;
    logic        dwb_err_o;

    modport master (
        output iwb_adr_i, iwb_cyc_i, iwb_stb_i,
        input  iwb_dat_o, iwb_ack_o, iwb_err_o,
        output dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_sel_i,
        output dwb_cyc_i, dwb_stb_i,
        input  dwb_dat_o, dwb_ack_o, dwb_err_o
    );

    modport slave (
        input  iwb_adr_i, iwb_cyc_i, iwb_stb_i,
        output iwb_dat_o, iwb_ack_o, iwb_err_o,
        input  dwb_adr_i, dwb_dat_i, dwb_we_i, dwb_sel_i,
        input  dwb_cyc_i, dwb_stb_i,
        output dwb_dat_o, dwb_ack_o, dwb_err_o
    );
endinterface

// File: rtl/wb_dual_port_mem_model.sv
// Dual-port Wishbone word memory with wait states, bus errors and tohost monitor.
// Ports: clk, rst_n (async low), bus (slave modport: iwb_* fetch, dwb_* data),
//        tohost_o, done_o, pass_o, fail_code_o.
// Optional macro WB_MEM_LFSR_STALL_EN adds LFSR-driven random wait states.
module wb_dual_port_mem_model #(
    parameter int          MEM_WORDS   = 8192,
    parameter int          ADDR_WIDTH  = 13,
    parameter int          IWAIT       = 0,
    parameter int          DWAIT       = 0,
    parameter int          TOHOST_WORD = 1024,
    parameter int          RANGE_CHECK = 1,
    parameter logic [31:0] RESET_IDATA = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    wb_dual_port_mem_model_if.slave    bus,
    output logic [31:0]                tohost_o,
    output logic                       done_o,
    output logic                       pass_o,
    output logic [30:0]                fail_code_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [ADDR_WIDTH:0]   LP_WORDS  = MEM_WORDS[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH-1:0] LP_TOHOST = TOHOST_WORD[ADDR_WIDTH-1:0];
    localparam logic [4:0]            LP_IWAIT  = IWAIT[4:0];
    localparam logic [4:0]            LP_DWAIT  = DWAIT[4:0];

    logic [31:0] r_mem [MEM_WORDS];

    // instruction port state
    logic [1:0]  r_istate;
    logic [4:0]  r_icnt;
    logic [31:0] r_iadr;
    logic        r_iack;
    logic        r_ierr;
    logic [31:0] r_idat;

    // data port state
    logic [1:0]  r_dstate;
    logic [4:0]  r_dcnt;
    logic [31:0] r_dadr;
    logic        r_dwe;
    logic [3:0]  r_dsel;
    logic [31:0] r_ddat;
    logic        r_dack;
    logic        r_derr;
    logic [31:0] r_ddato;

    // tohost monitor
    logic [31:0] r_tohost;
    logic        r_done;
    logic        r_pass;
    logic [30:0] r_fcode;

    logic [4:0]            w_iwait_tot;
    logic [4:0]            w_dwait_tot;
    logic                  w_ireq;
    logic                  w_dreq;
    logic [ADDR_WIDTH-1:0] w_iidx;
    logic [ADDR_WIDTH-1:0] w_didx;
    logic                  w_ioor;
    logic                  w_door;
    logic                  w_ifire;
    logic                  w_dfire;
    logic                  w_dcommit;
    logic [31:0]           w_dmerged;
    logic [31:0]           w_irdata;

`ifdef WB_MEM_LFSR_STALL_EN
    logic [15:0] r_lfsr;
    logic        w_fb;

    // Fibonacci LFSR, taps 16,14,13,11
    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
        end
    end

    assign w_iwait_tot = LP_IWAIT + {3'b000, r_lfsr[1:0]};
    assign w_dwait_tot = LP_DWAIT + {3'b000, r_lfsr[3:2]};
`else
    assign w_iwait_tot = LP_IWAIT;
    assign w_dwait_tot = LP_DWAIT;
`endif

    assign w_ireq = bus.iwb_cyc_i & bus.iwb_stb_i;
    assign w_dreq = bus.dwb_cyc_i & bus.dwb_stb_i;

    assign w_iidx = r_iadr[ADDR_WIDTH+1:2];
    assign w_didx = r_dadr[ADDR_WIDTH+1:2];

    assign w_ioor = ({1'b0, w_iidx} >= LP_WORDS) ||
                    ((RANGE_CHECK != 0) && (|r_iadr[31:ADDR_WIDTH+2]));
    assign w_door = ({1'b0, w_didx} >= LP_WORDS) ||
                    ((RANGE_CHECK != 0) && (|r_dadr[31:ADDR_WIDTH+2]));

    // response edge: only if the master still holds the cycle
    assign w_ifire   = (r_istate == S_RESP) && bus.iwb_cyc_i;
    assign w_dfire   = (r_dstate == S_RESP) && bus.dwb_cyc_i;
    assign w_dcommit = w_dfire && r_dwe && !w_door;

    always_comb begin
        w_dmerged = r_mem[w_didx];
        for (int b = 0; b < 4; b++) begin
            if (r_dsel[b]) begin
                w_dmerged[8*b +: 8] = r_ddat[8*b +: 8];
            end
        end
    end

    // write-first forwarding when a store commits to the word being fetched
    assign w_irdata = (w_dcommit && (w_didx == w_iidx)) ? w_dmerged
                                                        : r_mem[w_iidx];

    always_ff @(posedge clk) begin
        if (w_dcommit) begin
            r_mem[w_didx] <= w_dmerged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_istate <= S_IDLE;
            r_icnt   <= '0;
            r_iadr   <= '0;
            r_iack   <= 1'b0;
            r_ierr   <= 1'b0;
            r_idat   <= RESET_IDATA;
        end else begin
            r_iack <= 1'b0;
            r_ierr <= 1'b0;
            unique case (r_istate)
                S_IDLE: begin
                    if (w_ireq) begin
                        r_iadr <= bus.iwb_adr_i;
                        if (w_iwait_tot == 5'd0) begin
                            r_istate <= S_RESP;
                        end else begin
                            r_icnt   <= w_iwait_tot - 5'd1;
                            r_istate <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.iwb_cyc_i) begin
                        r_istate <= S_IDLE;
                    end else if (r_icnt == 5'd0) begin
                        r_istate <= S_RESP;
                    end else begin
                        r_icnt <= r_icnt - 5'd1;
                    end
                end
                S_RESP: begin
                    r_istate <= S_IDLE;
                    if (w_ifire) begin
                        if (w_ioor) begin
                            r_ierr <= 1'b1;
                        end else begin
                            r_iack <= 1'b1;
                            r_idat <= w_irdata;
                        end
                    end
                end
                default: r_istate <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dstate <= S_IDLE;
            r_dcnt   <= '0;
            r_dadr   <= '0;
            r_dwe    <= 1'b0;
            r_dsel   <= '0;
            r_ddat   <= '0;
            r_dack   <= 1'b0;
            r_derr   <= 1'b0;
            r_ddato  <= '0;
        end else begin
            r_dack <= 1'b0;
            r_derr <= 1'b0;
            unique case (r_dstate)
                S_IDLE: begin
                    if (w_dreq) begin
                        r_dadr <= bus.dwb_adr_i;
                        r_dwe  <= bus.dwb_we_i;
                        r_dsel <= bus.dwb_sel_i;
                        r_ddat <= bus.dwb_dat_i;
                        if (w_dwait_tot == 5'd0) begin
                            r_dstate <= S_RESP;
                        end else begin
                            r_dcnt   <= w_dwait_tot - 5'd1;
                            r_dstate <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.dwb_cyc_i) begin
                        r_dstate <= S_IDLE;
                    end else if (r_dcnt == 5'd0) begin
                        r_dstate <= S_RESP;
                    end else begin
                        r_dcnt <= r_dcnt - 5'd1;
                    end
                end
                S_RESP: begin
                    r_dstate <= S_IDLE;
                    if (w_dfire) begin
                        if (w_door) begin
                            r_derr <= 1'b1;
                        end else begin
                            r_dack <= 1'b1;
                            if (!r_dwe) begin
                                r_ddato <= r_mem[w_didx];
                            end
                        end
                    end
                end
                default: r_dstate <= S_IDLE;
            endcase
        end
    end

    // first nonzero tohost write terminates the test; later writes only
    // update the mirror
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tohost <= '0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_fcode  <= '0;
        end else if (w_dcommit && (w_didx == LP_TOHOST)) begin
            r_tohost <= w_dmerged;
            if ((w_dmerged != 32'd0) && !r_done) begin
                r_done  <= 1'b1;
                r_pass  <= (w_dmerged == 32'd1);
                r_fcode <= w_dmerged[31:1];
            end
        end
    end

    assign bus.iwb_dat_o = r_idat;
    assign bus.iwb_ack_o = r_iack;
    assign bus.iwb_err_o = r_ierr;
    assign bus.dwb_dat_o = r_ddato;
    assign bus.dwb_ack_o = r_dack;
    assign bus.dwb_err_o = r_derr;

    assign tohost_o    = r_tohost;
    assign done_o      = r_done;
    assign pass_o      = r_pass;
    assign fail_code_o = r_fcode;

endmodule

// File: doc/wb_dual_port_mem_model.md
Name: wb_dual_port_mem_model

Overview:
- Parametrised dual-port Wishbone memory for the rv32 compliance and integration benches.
- The instruction port and the data port share one word array, so self-modifying code and FENCE.I behave correctly.
- Per-port programmable wait states, registered read data on both ports, bus-error responses for out-of-range addresses, and a sticky tohost pass/fail monitor.
- Sits between custom_riscv_core and the bench; the bench only watches done_o/pass_o/fail_code_o.

Parameters:
- MEM_WORDS, 8192, number of 32-bit words in the array.
- ADDR_WIDTH, 13, word-index bits; index = adr[ADDR_WIDTH+1:2]; MEM_WORDS <= 2**ADDR_WIDTH.
- IWAIT, 0, extra wait cycles before iwb_ack_o (0..15).
- DWAIT, 0, extra wait cycles before dwb_ack_o/dwb_err_o (0..15).
- TOHOST_WORD, 1024, word index monitored for tohost writes.
- RANGE_CHECK, 1, 1: a nonzero adr[31:ADDR_WIDTH+2] is out of range; 0: upper bits ignored (aliasing).
- RESET_IDATA, 32'h00000013, iwb_dat_o value at reset (NOP).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- iwb_adr_i  in  32  instruction byte address.
- iwb_cyc_i  in  1  instruction bus cycle.
- iwb_stb_i  in  1  instruction strobe.
- iwb_dat_o  out  32  fetched word.
- iwb_ack_o  out  1  fetch acknowledge, one-cycle pulse.
- iwb_err_o  out  1  fetch out-of-range, one-cycle pulse.
- dwb_adr_i  in  32  data byte address.
- dwb_dat_i  in  32  write data.
- dwb_we_i  in  1  write enable.
- dwb_sel_i  in  4  byte lane select.
- dwb_cyc_i  in  1  data bus cycle.
- dwb_stb_i  in  1  data strobe.
- dwb_dat_o  out  32  read word, full 32 bits; the master extracts lanes.
- dwb_ack_o  out  1  data acknowledge, one-cycle pulse.
- dwb_err_o  out  1  data out-of-range, one-cycle pulse.
- tohost_o  out  32  last value written to TOHOST_WORD.
- done_o  out  1  sticky; set by a nonzero tohost write.
- pass_o  out  1  sticky; set with done_o when the value is 1.
- fail_code_o  out  31  value>>1 of the terminating write; 0 on pass.

Behaviour:
- Reset (async assert, sync release):
  - All acks and errs 0; iwb_dat_o = RESET_IDATA; dwb_dat_o = 0.
  - tohost_o, done_o, pass_o, fail_code_o = 0; both port FSMs IDLE.
  - Array contents are not reset; the bench preloads them.
- Port FSM, independent per port: IDLE -> WAIT -> RESP -> IDLE.
  - IDLE: if cyc&stb is sampled high at edge k, latch address, we, sel, write data; load counter = WAIT param; go to WAIT, or directly to RESP when the param is 0.
  - WAIT: decrement each cycle; on 0 go to RESP.
  - If cyc drops in WAIT: abort to IDLE; no ack, no write.
- RESP timing:
  - Ack or err is visible for exactly one cycle, first visible after edge k+1+WAIT. With WAIT=0, latency is 1 cycle.
  - In the ack cycle, stb is ignored; the next request is sampled no earlier than the following edge.
  - Minimum issue interval is 2+WAIT cycles.
- Reads: data is registered at the edge that raises ack and reflects the array at that edge.
- Writes: committed at the edge that raises dwb_ack_o, with per-byte sel masking; unselected bytes are preserved.
  - sel = 0 acks with no change.
- Same-word collision on the same edge (data write committing, instruction read sampling): the instruction port returns the merged new value (write-first).
- Out of range (index >= MEM_WORDS, or RANGE_CHECK and nonzero upper bits):
  - err is asserted instead of ack, at the same timing.
  - No write; read data holds its previous value.
- adr[1:0] is ignored for word selection on both ports.
- tohost:
  - A committed write to TOHOST_WORD updates tohost_o with the merged word.
  - If that word is nonzero and done_o=0: set done_o; pass_o = (word==1); fail_code_o = word[31:1].
  - Later writes update tohost_o only; done_o, pass_o and fail_code_o stay frozen until reset.
- Reset mid-transaction aborts both ports. A write whose ack edge has not occurred is never committed.

Optional Feature:
- Macro: WB_MEM_LFSR_STALL_EN.
- Defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - Each accepted request adds lfsr[1:0] (0..3) extra wait cycles on top of IWAIT/DWAIT. The instruction port uses bits [1:0] and the data port bits [3:2], both sampled at acceptance.
  - Behaviour is deterministic for a given stimulus.
- Undefined: wait counts are exactly IWAIT/DWAIT; no LFSR logic.

Test Plan:
- IWAIT=0: fetch adr 0x0 with mem[0]=0x00500093 -> iwb_ack_o high one cycle after the request edge, iwb_dat_o=0x00500093; a held stb gives the next ack 2 cycles later.
- DWAIT=2: write 0xDEADBEEF, sel=4'b0101 to word 5 preloaded 0x11223344 -> ack after 3 cycles; then read word 5 -> 0x11AD33EF.
- Same-edge collision: data write 0x00000073 to word 8 committing on the edge where the fetch of word 8 samples -> iwb_dat_o=0x00000073.
- Write adr 0x0001_0000 with RANGE_CHECK=1 -> dwb_err_o pulse, no ack, word 0 unchanged. Write 0x00000007 to word 1024 -> done_o=1, pass_o=0, fail_code_o=3; a later write of 1 leaves them frozen, tohost_o=1.
- Drop cyc during DWAIT=3 write, then assert rst_n=0 during a pending fetch -> no write, no ack; post-reset iwb_dat_o=0x00000013.
- With WB_MEM_LFSR_STALL_EN: 100 sequential fetches -> every ack latency in 1..4 cycles and data correct; repeating the run gives an identical latency sequence.
